// File: rtl/spart_driver_if.sv
// spart_driver_if: SPART processor-side control and queue-flag signals
// master: drives iocs_n, iorw_n, ioaddr; samples tx_q_full, rx_q_empty
// slave: the SPART side of the same signals
interface spart_driver_if;
  logic iocs_n;
  logic iorw_n;
  logic [1:0] ioaddr;
  logic tx_q_full;
  logic rx_q_empty;
  modport master(output iocs_n, iorw_n, ioaddr, input tx_q_full, rx_q_empty);
  modport slave(input iocs_n, iorw_n, ioaddr, output tx_q_full, rx_q_empty);
endinterface

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from br_cfg, then echoes every RX byte back to TX
// ports: clk, rst_n (async active-low), br_cfg (async switches), bus (SPART control/flags),
// databus (shared 3-state data), last_rx (last byte read), byte_cnt (completed echoes mod 256)
module spart_driver (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  output logic [7:0]     last_rx,
  output logic [7:0]     byte_cnt
);
  typedef enum logic [2:0] {CFG_LO, CFG_HI, WAIT_RX, READ, WAIT_TX, WRITE} state_t;
  state_t state;
  logic [1:0] sync0, sync1, cfg_applied;
  logic [15:0] div_new, div_cur;
  logic [7:0] dout;
  logic drive;
  function automatic logic [15:0] divisor(input logic [1:0] c);
    return c == 2'b00 ? 16'h028B : c == 2'b01 ? 16'h00D9 : c == 2'b10 ? 16'h006C : 16'h0036;
  endfunction
  // Bus pins decode the state register; rst_n gating idles the bus the instant reset asserts.
  always_comb begin
    div_new = divisor(sync1);
    div_cur = divisor(cfg_applied);
    drive = rst_n && (state == CFG_LO || state == CFG_HI || state == WRITE);
    dout = state == CFG_LO ? div_new[7:0] : state == CFG_HI ? div_cur[15:8] : last_rx;
    bus.iocs_n = !(drive || (rst_n && state == READ));
    bus.iorw_n = !drive;
    bus.ioaddr = !rst_n ? 2'b00 : state == CFG_LO ? 2'b10 : state == CFG_HI ? 2'b11 : 2'b00;
  end
  assign databus = drive ? dout : 8'hzz;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CFG_LO;
      sync0 <= 2'b00;
      sync1 <= 2'b00;
      cfg_applied <= 2'b00;
      last_rx <= 8'h00;
      byte_cnt <= 8'h00;
    end else begin
      sync0 <= br_cfg;
      sync1 <= sync0;
      case (state)
        CFG_LO: begin
          cfg_applied <= sync1;
          state <= CFG_HI;
        end
        CFG_HI: state <= WAIT_RX;
        WAIT_RX: state <= sync1 != cfg_applied ? CFG_LO : !bus.rx_q_empty ? READ : WAIT_RX;
        READ: begin
          last_rx <= databus;
          state <= WAIT_TX;
        end
        WAIT_TX: state <= bus.tx_q_full ? WAIT_TX : WRITE;
        WRITE: begin
          byte_cnt <= byte_cnt + 8'd1;
          state <= WAIT_RX;
        end
        default: state <= CFG_LO;
      endcase
    end
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: scoreboard bench with a SPART bus-functional model for spart_driver
module tb_spart_driver;
  logic clk = 0;
  logic rst_n = 1;
  logic [1:0] br_cfg = 2'b00;
  wire [7:0] databus;
  logic [7:0] last_rx, byte_cnt;
  spart_driver_if bus();
  spart_driver dut (
    .clk(clk),
    .rst_n(rst_n),
    .br_cfg(br_cfg),
    .bus(bus),
    .databus(databus),
    .last_rx(last_rx),
    .byte_cnt(byte_cnt)
  );
  always #5 clk = ~clk;
  logic [7:0] rx_mem [0:511];
  int rd_idx = 0, wr_idx = 0, cyc = 0, rd_cyc = 0, wr_cyc = 0, rd_cnt = 0;
  int passed = 0, total = 0;
  int n, c0;
  logic pop_pend = 0, tx_full = 0, rx_empty = 1;
  logic [10:0] exp_q [$];
  logic [10:0] e;
  assign bus.tx_q_full = tx_full;
  assign bus.rx_q_empty = rx_empty;
  wire rd_sel = !bus.iocs_n && bus.iorw_n && bus.ioaddr == 2'b00;
  assign databus = rd_sel ? rx_mem[rd_idx[8:0]] : 8'hzz;
  task automatic check(string name, logic [15:0] got, logic [15:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask
  task automatic tick(int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic exp_wr(logic [1:0] a, logic [7:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask
  task automatic exp_rd(logic [7:0] d);
    exp_q.push_back({1'b1, 2'b00, d});
  endtask
  task automatic rx_push(logic [7:0] d);
    rx_mem[wr_idx[8:0]] = d;
    wr_idx++;
  endtask
  task automatic drain(string name, int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    check(name, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask
  task automatic wait_read(string name);
    int k = 0;
    int r0 = rd_cnt;
    while (rd_cnt == r0 && k < 20) begin
      tick();
      k++;
    end
    check(name, 16'(rd_cnt - r0), 16'd1);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // SPART model: pops RX after the read's closing edge, logs every access against the scoreboard.
  always @(negedge clk) begin
    if (pop_pend) begin
      rd_idx++;
      pop_pend = 0;
    end
    rx_empty = rd_idx == wr_idx;
    if (rst_n && !bus.iocs_n) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_txn: got rw=%b addr=%b data=%h expected none", bus.iorw_n, bus.ioaddr, databus);
      end else begin
        e = exp_q.pop_front();
        check("bus_txn", 16'({bus.iorw_n, bus.ioaddr, databus}), 16'(e));
      end
      if (rd_sel) begin
        pop_pend = 1;
        rd_cyc = cyc;
        rd_cnt++;
      end else if (!bus.iorw_n && bus.ioaddr == 2'b00) wr_cyc = cyc;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    #1 rst_n = 0;
    @(negedge clk);
    check("rst_iocs_n", 16'(bus.iocs_n), 16'd1);
    check("rst_iorw_n", 16'(bus.iorw_n), 16'd1);
    check("rst_ioaddr", 16'(bus.ioaddr), 16'd0);
    check("rst_db_z", 16'(dut.drive), 16'd0);
    check("rst_last_rx", 16'(last_rx), 16'h00);
    check("rst_byte_cnt", 16'(byte_cnt), 16'h00);
    exp_wr(2'b10, 8'h8B);
    exp_wr(2'b11, 8'h02);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("cyc1_addr", 16'({bus.iocs_n, bus.iorw_n, bus.ioaddr}), 16'b0010);
    @(negedge clk);
    check("cyc2_addr", 16'({bus.iocs_n, bus.iorw_n, bus.ioaddr}), 16'b0011);
    @(negedge clk);
    check("idle_bus", 16'({bus.iocs_n, bus.iorw_n, bus.ioaddr}), 16'b1100);
    check("idle_db_z", 16'(dut.drive), 16'd0);
    drain("init_writes", 5);
    rst_n = 0;
    br_cfg = 2'b11;
    tick(2);
    exp_wr(2'b10, 8'h8B);
    exp_wr(2'b11, 8'h02);
    exp_wr(2'b10, 8'h36);
    exp_wr(2'b11, 8'h00);
    rst_n = 1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (!bus.iocs_n && bus.ioaddr == 2'b11) n++;
    end
    check("reprog_within_5", 16'(n), 16'd2);
    drain("reprog_writes", 10);
    tick(3);
    exp_rd(8'h5A);
    exp_wr(2'b00, 8'h5A);
    rx_push(8'h5A);
    drain("echo_5a", 20);
    check("echo_gap", 16'(wr_cyc - rd_cyc), 16'd2);
    check("last_rx_5a", 16'(last_rx), 16'h5A);
    check("cnt_1", 16'(byte_cnt), 16'd1);
    tx_full = 1;
    exp_rd(8'hA5);
    exp_wr(2'b00, 8'hA5);
    rx_push(8'hA5);
    wait_read("read_a5");
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.iocs_n) n++;
    end
    check("stall_idle", 16'(n), 16'd0);
    check("stall_hold", 16'(last_rx), 16'hA5);
    @(posedge clk);
    #1 tx_full = 0;
    c0 = cyc;
    drain("stall_release", 10);
    check("write_after_release", 16'(wr_cyc - c0), 16'd1);
    check("cnt_2", 16'(byte_cnt), 16'd2);
    br_cfg = 2'b01;
    exp_wr(2'b10, 8'hD9);
    exp_wr(2'b11, 8'h00);
    drain("cfg01", 10);
    tx_full = 1;
    exp_rd(8'h3C);
    rx_push(8'h3C);
    wait_read("read_3c");
    br_cfg = 2'b10;
    tick(6);
    exp_wr(2'b00, 8'h3C);
    exp_wr(2'b10, 8'h6C);
    exp_wr(2'b11, 8'h00);
    tx_full = 0;
    drain("echo_before_cfg", 15);
    check("cnt_3", 16'(byte_cnt), 16'd3);
    for (int i = 0; i < 256; i++) begin
      exp_rd(8'(i * 7 + 3));
      exp_wr(2'b00, 8'(i * 7 + 3));
      rx_push(8'(i * 7 + 3));
    end
    drain("burst_256", 1100);
    check("cnt_wrap", 16'(byte_cnt), 16'd3);
    exp_rd(8'h77);
    rx_push(8'h77);
    wait_read("read_77");
    @(posedge clk);
    #2;
    check("write_live", 16'({bus.iocs_n, bus.iorw_n}), 16'b00);
    rst_n = 0;
    #1;
    check("rst_mid_iocs_n", 16'(bus.iocs_n), 16'd1);
    check("rst_mid_db_z", 16'(dut.drive), 16'd0);
    exp_wr(2'b10, 8'h8B);
    exp_wr(2'b11, 8'h02);
    exp_wr(2'b10, 8'h6C);
    exp_wr(2'b11, 8'h00);
    tick(2);
    rst_n = 1;
    drain("reprog_after_reset", 15);
    tick(5);
    check("cnt_after_reset", 16'(byte_cnt), 16'd0);
    check("no_stale_echo", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
